xg_tx_gearbox_feeder: RTL and testbench



---
 rtl/xg_tx_gearbox_feeder_if.sv | 22 ++
 rtl/xg_tx_gearbox_feeder.sv | 92 +++++++++
 tb/tb_xg_tx_gearbox_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/xg_tx_gearbox_feeder_if.sv
// Block handshake between the 64b/66b encoder and the gearbox feeder.
// master: encoder side (drives block), slave: feeder side (drives ready).
interface xg_tx_gearbox_feeder_if;
  logic        blk_valid;
  logic        blk_ready;
  logic [1:0]  blk_header;
  logic [63:0] blk_data;

  modport master (
    output blk_valid,
    output blk_header,
    output blk_data,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_header,
    input  blk_data,
    output blk_ready
  );
endinterface

// File: rtl/xg_tx_gearbox_feeder.sv
// 10GBASE-R TX feeder for the external 64b/66b gearbox (32-bit fabric).
// Ports: clk, rst_n, blk (block handshake, slave), tx_sequence/
// tx_header/tx_data to the transceiver, tx_underflow, underflow_count.
module xg_tx_gearbox_feeder #(
  parameter bit SCRAMBLE       = 1'b1,
  parameter int UNDERFLOW_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  xg_tx_gearbox_feeder_if.slave     blk,
  output logic [5:0]                tx_sequence,
  output logic [1:0]                tx_header,
  output logic [31:0]               tx_data,
  output logic                      tx_underflow,
  output logic [UNDERFLOW_BITS-1:0] underflow_count
);

  localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_HDR  = 2'b10;
  localparam logic [5:0]  PAUSE     = 6'd32;
  localparam logic [UNDERFLOW_BITS-1:0] UONE = 1;

  // e[57:0] holds the previous 58 scrambled bits, oldest at e[0];
  // e[58+i] is scrambled bit i of this block.
  function automatic logic [63:0] scramble(
    input logic [63:0] d,
    input logic [57:0] st
  );
    logic [121:0] e;
    e = {64'd0, st};
    for (int i = 0; i < 64; i++) begin
      e[58+i] = d[i] ^ e[i+19] ^ e[i];
    end
    return e[121:58];
  endfunction

  logic [5:0]  cnt;
  logic [57:0] scr_q;
  logic [31:0] held;
  logic        load;
  logic [1:0]  src_hdr;
  logic [63:0] src_data;
  logic [63:0] scr;
  logic [63:0] pay;

  assign load          = ~cnt[0] && (cnt != PAUSE);
  assign blk.blk_ready = load;

  always_comb begin
    src_hdr  = IDLE_HDR;
    src_data = IDLE_DATA;
    if (blk.blk_valid) begin
      src_hdr  = blk.blk_header;
      src_data = blk.blk_data;
    end
  end

  assign scr = scramble(src_data, scr_q);
  assign pay = SCRAMBLE ? scr : src_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      scr_q           <= '1;
      held            <= '0;
      tx_sequence     <= '0;
      tx_header       <= '0;
      tx_data         <= '0;
      tx_underflow    <= 1'b0;
      underflow_count <= '0;
    end else begin
      cnt          <= (cnt == PAUSE) ? 6'd0 : cnt + 6'd1;
      tx_sequence  <= cnt;
      tx_underflow <= 1'b0;
      if (load) begin
        tx_header <= src_hdr;
        tx_data   <= pay[31:0];
        held      <= pay[63:32];
        // State tracks the scrambled stream even in passthrough.
        scr_q     <= scr[63:6];
        if (!blk.blk_valid) begin
          tx_underflow <= 1'b1;
          if (~&underflow_count)
            underflow_count <= underflow_count + UONE;
        end
      end else if (cnt != PAUSE) begin
        tx_data <= held;
      end
    end
  end

endmodule

// File: tb/tb_xg_tx_gearbox_feeder.sv
// Self-checking bench for xg_tx_gearbox_feeder.
// Three instances: passthrough, scrambled, and 4-bit underflow counter.
module tb_xg_tx_gearbox_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xg_tx_gearbox_feeder_if ifa ();
  xg_tx_gearbox_feeder_if ifb ();
  xg_tx_gearbox_feeder_if ifc ();

  assign ifb.blk_valid  = ifa.blk_valid;
  assign ifb.blk_header = ifa.blk_header;
  assign ifb.blk_data   = ifa.blk_data;
  assign ifc.blk_valid  = 1'b0;
  assign ifc.blk_header = 2'b01;
  assign ifc.blk_data   = 64'd0;

  logic [5:0]  seq_a, seq_b, seq_c;
  logic [1:0]  hdr_a, hdr_b, hdr_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic        unf_a, unf_b, unf_c;
  logic [15:0] uc_a, uc_b;
  logic [3:0]  uc_c;

  xg_tx_gearbox_feeder #(.SCRAMBLE(1'b0), .UNDERFLOW_BITS(16)) u_a (
    .clk(clk), .rst_n(rst_n), .blk(ifa),
    .tx_sequence(seq_a), .tx_header(hdr_a), .tx_data(dat_a),
    .tx_underflow(unf_a), .underflow_count(uc_a)
  );

  xg_tx_gearbox_feeder #(.SCRAMBLE(1'b1), .UNDERFLOW_BITS(16)) u_b (
    .clk(clk), .rst_n(rst_n), .blk(ifb),
    .tx_sequence(seq_b), .tx_header(hdr_b), .tx_data(dat_b),
    .tx_underflow(unf_b), .underflow_count(uc_b)
  );

  xg_tx_gearbox_feeder #(.SCRAMBLE(1'b0), .UNDERFLOW_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .blk(ifc),
    .tx_sequence(seq_c), .tx_header(hdr_c), .tx_data(dat_c),
    .tx_underflow(unf_c), .underflow_count(uc_c)
  );

  typedef struct {
    logic [1:0]  hdr;
    logic [31:0] a;
    logic [31:0] b;
    logic        unf;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  int          m_cnt;
  int          acc;
  logic [15:0] m_uc;
  logic [57:0] sr_m;
  logic [57:0] sr_d;
  logic [31:0] lo_b;
  ent_t        last;
  ent_t        q[$];
  logic [63:0] qin[$];

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reference: sr_m[0] is the most recent scrambled bit.
  task automatic scr_ref(input logic [63:0] d, output logic [63:0] s);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b     = d[i] ^ sr_m[38] ^ sr_m[57];
      s[i]  = b;
      sr_m  = {sr_m[56:0], b};
    end
  endtask

  task automatic descr(input logic [63:0] s, output logic [63:0] d);
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ sr_d[38] ^ sr_d[57];
      sr_d = {sr_d[56:0], s[i]};
    end
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_seq", seq_a, 0);
    check("rst_hdr", hdr_a, 0);
    check("rst_data", dat_a, 0);
    check("rst_unf", unf_a, 0);
    check("rst_ucnt", uc_a, 0);
    check("rst_data_b", dat_b, 0);
    check("rst_ucnt_c", uc_c, 0);
    check("rst_ready", ifa.blk_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    acc   = 0;
    m_uc  = '0;
    sr_m  = '1;
    sr_d  = '1;
    lo_b  = '0;
    last  = '{hdr: 2'b00, a: 32'd0, b: 32'd0, unf: 1'b0};
    q.delete();
    qin.delete();
  endtask

  task automatic cycle(
    input logic        v,
    input logic [1:0]  h,
    input logic [63:0] d
  );
    logic        ld;
    logic [1:0]  ph;
    logic [63:0] pd, sd, full, rec, orig;
    ent_t        e;
    ld = (m_cnt % 2 == 0) && (m_cnt != 32);
    check("ready", ifa.blk_ready, ld);
    if (ifa.blk_ready) acc++;
    ifa.blk_valid  = v;
    ifa.blk_header = h;
    ifa.blk_data   = d;
    if (ld) begin
      ph = v ? h : 2'b10;
      pd = v ? d : 64'h1E;
      scr_ref(pd, sd);
      qin.push_back(pd);
      q.push_back('{hdr: ph, a: pd[31:0], b: sd[31:0], unf: ~v});
      q.push_back('{hdr: ph, a: pd[63:32], b: sd[63:32], unf: 1'b0});
      if (!v && m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
    end
    @(negedge clk);
    check("seq_a", seq_a, m_cnt);
    check("seq_b", seq_b, m_cnt);
    e = last;
    e.unf = 1'b0;
    if (m_cnt != 32) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_underrun got=0 exp=entry t=%0t", $time);
      end else begin
        e = q.pop_front();
        last = e;
      end
    end
    check("hdr_a", hdr_a, e.hdr);
    check("data_a", dat_a, e.a);
    check("unf_a", unf_a, e.unf);
    check("hdr_b", hdr_b, e.hdr);
    check("data_b", dat_b, e.b);
    check("unf_b", unf_b, e.unf);
    check("ucnt_a", uc_a, m_uc);
    check("ucnt_b", uc_b, m_uc);
    if (m_cnt != 32) begin
      if (m_cnt % 2 == 0) begin
        lo_b = dat_b;
      end else if (qin.size() > 0) begin
        full = {dat_b, lo_b};
        descr(full, rec);
        orig = qin.pop_front();
        check("descramble", rec, orig);
      end
    end
    if (m_cnt == 32) begin
      check("per_period", acc, 16);
      acc   = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    int          per;
    ifa.blk_valid  = 1'b0;
    ifa.blk_header = 2'b00;
    ifa.blk_data   = 64'd0;
    @(negedge clk);
    do_reset();

    cycle(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
    check("pass_lo", dat_a, 32'h89AB_CDEF);
    check("pass_lo_hdr", hdr_a, 2'b01);
    cycle(1'b0, 2'b00, 64'd0);
    check("pass_hi", dat_a, 32'h0123_4567);
    check("pass_hi_hdr", hdr_a, 2'b01);

    per = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_cnt == 0) per++;
      v = !(per == 5 && m_cnt == 4);
      h = $urandom_range(1) ? 2'b01 : 2'b10;
      d = {$urandom, $urandom};
      if (per == 5 && m_cnt == 4) begin
        cycle(v, h, d);
        check("uf_lo_hdr", hdr_a, 2'b10);
        check("uf_lo_data", dat_a, 32'h0000_001E);
        check("uf_pulse", unf_a, 1);
        cycle(1'b1, h, d);
        check("uf_hi_data", dat_a, 32'h0);
        check("uf_pulse_end", unf_a, 0);
        check("uf_count", uc_a, 1);
      end else begin
        cycle(v, h, d);
      end
    end
    check("uf_count_end", uc_a, 1);

    while (m_cnt != 17) cycle(1'b1, 2'b01, {$urandom, $urandom});
    do_reset();

    for (int i = 0; i < 140; i++) begin
      v = ($urandom_range(3) != 0);
      h = $urandom_range(1) ? 2'b01 : 2'b10;
      cycle(v, h, {$urandom, $urandom});
    end
    check("sat_c", uc_c, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
